// File: rtl/nios_ii_irq_ctrl_if.sv
// Avalon-MM slave bus for the Nios II interrupt controller.
// 16-bit data, 3-bit word address, fixed 1-cycle read latency, no wait states.
interface nios_ii_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_ii_irq_ctrl.sv
// Interrupt aggregation for the Nios II: latches up to NUM_IRQ request lines in level or
// rising-edge mode, masks them and drives one registered irq plus a lowest-index vector.
// All per-line state is held 16 bits wide; lanes at or above NUM_IRQ are forced to 0.
module nios_ii_irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [15:0] EDGE_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  nios_ii_irq_ctrl_if.slave  bus,
  output logic               irq
);

  localparam logic [15:0] LaneMask = 16'((17'd1 << NUM_IRQ) - 17'd1);

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrPending = 3'd1;
  localparam logic [2:0] AddrMask    = 3'd2;
  localparam logic [2:0] AddrEdge    = 3'd3;
  localparam logic [2:0] AddrActive  = 3'd4;
  localparam logic [2:0] AddrVector  = 3'd5;
  localparam logic [2:0] AddrSwtrig  = 3'd6;

  logic [15:0] r_pending;
  logic [15:0] r_mask;
  logic [15:0] r_edge;
  logic [15:0] r_irq_d;
  logic [15:0] r_readdata;
  logic        r_irq;

  logic        w_wr;
  logic [15:0] w_wdata;
  logic [15:0] w_irq_in;
  logic [15:0] w_rise;
  logic [15:0] w_w1c;
  logic [15:0] w_swtrig;
  logic [15:0] w_pending_d;
  logic [15:0] w_active;
  logic [3:0]  w_vec_idx;
  logic [15:0] w_vector;
  logic [15:0] w_rd_mux;

  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_wdata  = bus.writedata & LaneMask;
  assign w_irq_in = 16'(irq_in) & LaneMask;
  assign w_rise   = w_irq_in & ~r_irq_d;
  assign w_w1c    = (w_wr && (bus.address == AddrPending)) ? w_wdata : 16'h0000;
  assign w_swtrig = (w_wr && (bus.address == AddrSwtrig))  ? w_wdata : 16'h0000;
  assign w_active = r_pending & r_mask;

  // Edge lanes: a set (rise or software trigger) beats a same-cycle W1C so no event is lost.
  // Level lanes simply track the input. Mode is the EDGE value before this cycle's write.
  assign w_pending_d = LaneMask & ((r_edge & (w_rise | w_swtrig | (r_pending & ~w_w1c)))
                                 | (~r_edge & w_irq_in));

  // Lowest-index active line wins; scan from the top so the last hit is the lowest.
  always_comb begin
    w_vec_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_active[i]) begin
        w_vec_idx = 4'(i);
      end
    end
  end

  assign w_vector = {|w_active, 11'b0, w_vec_idx};

  // Read mux over pre-edge register state; chipselect does not gate the read path.
  always_comb begin
    w_rd_mux = 16'h0000;
    case (bus.address)
      AddrStatus:  w_rd_mux = w_irq_in;
      AddrPending: w_rd_mux = r_pending;
      AddrMask:    w_rd_mux = r_mask;
      AddrEdge:    w_rd_mux = r_edge;
      AddrActive:  w_rd_mux = w_active;
      AddrVector:  w_rd_mux = w_vector;
      default:     w_rd_mux = 16'h0000;
    endcase
  end

  // All controller state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending  <= 16'h0000;
      r_mask     <= 16'h0000;
      r_edge     <= EDGE_RESET & LaneMask;
      r_irq_d    <= 16'h0000;
      r_readdata <= 16'h0000;
      r_irq      <= 1'b0;
    end else begin
      r_irq_d    <= w_irq_in;
      r_pending  <= w_pending_d;
      r_readdata <= w_rd_mux;
      r_irq      <= |w_active;
      if (w_wr && (bus.address == AddrMask)) begin
        r_mask <= w_wdata;
      end
      if (w_wr && (bus.address == AddrEdge)) begin
        r_edge <= w_wdata;
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_nios_ii_irq_ctrl.sv
// Directed bench for nios_ii_irq_ctrl with a scoreboard queue of expected results.
module tb_nios_ii_irq_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq;

  nios_ii_irq_ctrl_if bus ();

  nios_ii_irq_ctrl #(
    .NUM_IRQ    (8),
    .EDGE_RESET (16'h0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq_in  (irq_in),
    .bus     (bus.slave),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic pop_cmp(input logic [15:0] act);
    item_t it;
    it = sb.pop_front();
    n_tests++;
    assert (act === it.exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", it.tag, act, it.exp);
    end
  endtask

  task automatic rd(input logic [2:0] addr, input logic [15:0] exp, input string tag);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    push(tag, exp);
    tick();
    bus.chipselect = 1'b0;
    pop_cmp(bus.readdata);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    push(tag, 16'(exp));
    pop_cmp(16'(irq));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic m_pend;
    logic m_exp;

    reset_n        = 1'b0;
    irq_in         = 8'hFF;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'h0000;

    // 1. Reset with all lines high
    for (int i = 0; i < 2; i++) begin
      push("rst_readdata", 16'h0000);
      tick();
      pop_cmp(bus.readdata);
      chk_irq(1'b0, "rst_irq");
    end
    reset_n = 1'b1;
    tick();
    chk_irq(1'b0, "post_rst_irq");
    rd(3'd1, 16'h00FF, "post_rst_pending");
    rd(3'd0, 16'h00FF, "post_rst_status");
    rd(3'd3, 16'h0000, "post_rst_edge");
    rd(3'd5, 16'h0000, "post_rst_vector_none");
    chk_irq(1'b0, "post_rst_irq_masked");

    // 2. Level mode on line 0
    irq_in = 8'h00;
    tick();
    wr(3'd2, 16'h0001);
    m_pend = 1'b0;
    for (int c = 0; c < 12; c++) begin
      irq_in = (c >= 3 && c <= 7) ? 8'h01 : 8'h00;
      tick();
      m_exp  = m_pend;
      m_pend = irq_in[0];
      chk_irq(m_exp, $sformatf("level_irq_c%0d", c));
    end
    irq_in = 8'h01;
    tick();
    rd(3'd5, 16'h8000, "level_vector");
    rd(3'd4, 16'h0001, "level_active");
    irq_in = 8'h00;
    tick();
    tick();
    chk_irq(1'b0, "level_irq_drop");

    // 3. Edge mode on line 0
    wr(3'd3, 16'h0001);
    tick();
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    chk_irq(1'b1, "edge_irq_set");
    tick();
    tick();
    chk_irq(1'b1, "edge_irq_held");
    wr(3'd1, 16'h0001);
    chk_irq(1'b1, "edge_w1c_edge1");
    tick();
    chk_irq(1'b0, "edge_w1c_edge2");
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    chk_irq(1'b1, "edge_irq_set2");
    // Rise coincident with W1C on the same line
    bus.address    = 3'd1;
    bus.writedata  = 16'h0001;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    irq_in         = 8'h01;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    irq_in         = 8'h00;
    tick();
    tick();
    chk_irq(1'b1, "edge_rise_beats_w1c");
    rd(3'd1, 16'h0001, "edge_pending_kept");
    wr(3'd1, 16'h0001);
    tick();
    tick();
    chk_irq(1'b0, "edge_cleared");

    // 4. Priority vector via software trigger
    wr(3'd3, 16'h00FF);
    wr(3'd2, 16'hFFFF);
    rd(3'd2, 16'h00FF, "mask_upper_ignored");
    rd(3'd3, 16'h00FF, "edge_readback");
    wr(3'd6, 16'h00A4);
    rd(3'd4, 16'h00A4, "prio_active");
    rd(3'd5, 16'h8002, "prio_vector");
    chk_irq(1'b1, "prio_irq");
    rd(3'd6, 16'h0000, "swtrig_reads0");
    wr(3'd1, 16'h0004);
    rd(3'd5, 16'h8005, "prio_vector_after_w1c");
    rd(3'd1, 16'h00A0, "prio_pending_after_w1c");
    wr(3'd7, 16'hFFFF);
    rd(3'd7, 16'h0000, "addr7_reads0");
    rd(3'd2, 16'h00FF, "addr7_write_ignored");

    // 5. Masked capture on line 3
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h00FF);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    chk_irq(1'b0, "masked_irq_low");
    rd(3'd1, 16'h0008, "masked_pending");
    wr(3'd2, 16'h0008);
    chk_irq(1'b0, "unmask_edge1");
    tick();
    chk_irq(1'b1, "unmask_edge2");

    // 6. Reset in the middle of activity
    wr(3'd1, 16'h0008);
    wr(3'd6, 16'h00A4);
    wr(3'd2, 16'h00FF);
    tick();
    chk_irq(1'b1, "midrst_pre_irq");
    rd(3'd1, 16'h00A4, "midrst_pre_pending");
    reset_n = 1'b0;
    push("midrst_readdata", 16'h0000);
    tick();
    pop_cmp(bus.readdata);
    chk_irq(1'b0, "midrst_irq");
    reset_n = 1'b1;
    tick();
    rd(3'd1, 16'h0000, "midrst_pending");
    rd(3'd2, 16'h0000, "midrst_mask");
    rd(3'd3, 16'h0000, "midrst_edge");
    chk_irq(1'b0, "midrst_irq_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_ii_irq_ctrl.md
Name: nios_ii_irq_ctrl

Overview:
- Interrupt aggregation stage directly downstream of the interval timer and the other peripheral IRQ sources.
- Collects up to NUM_IRQ request lines (timer irq on bit 0) and latches each in level or rising-edge mode.
- Applies a per-line mask and drives one registered interrupt to the Nios II, plus a lowest-index vector register.
- Programmed over a 16-bit Avalon-MM slave: fixed 1-cycle read latency, no wait states.

Parameters:
NUM_IRQ, 8, number of request inputs, legal range 1..16
EDGE_RESET, 0, reset value of the EDGE mode register (NUM_IRQ bits)

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
irq_in  input  NUM_IRQ  request lines, synchronous to clk, active high
address  input  3  register word select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, qualified by chipselect
writedata  input  16  write data
readdata  output  16  registered read data
irq  output  1  interrupt to CPU, registered

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on reset_n. While reset_n=0 at a rising edge:
  - irq=0, readdata=0, pending=0, mask=0, irq_d=0.
  - edge=EDGE_RESET.
- Write strobe: wr = chipselect & ~write_n. Bits above NUM_IRQ-1 are ignored on write and read as 0.
- Register map:
  - 0 STATUS (RO): raw irq_in.
  - 1 PENDING: read gives pending; write is W1C for edge-mode bits and has no effect on level-mode bits.
  - 2 MASK (RW).
  - 3 EDGE (RW): 1 = rising-edge capture, 0 = level.
  - 4 ACTIVE (RO): pending & mask.
  - 5 VECTOR (RO): bit15 = |ACTIVE; bits3:0 = index of lowest set ACTIVE bit, 0 when none; other bits 0.
  - 6 SWTRIG (WO, reads 0): write 1 sets pending for edge-mode bits; ignored for level-mode bits.
  - 7: reads 0, writes ignored.
- Edge detect:
  - irq_d <= irq_in every cycle; rise = irq_in & ~irq_d.
  - Because irq_d resets to 0, a line already high when reset deasserts registers as a rise on the first cycle out of reset.
- Pending update, per bit i, each cycle:
  - Level mode: pending[i] <= irq_in[i].
  - Edge mode: set if rise[i] or SWTRIG bit i written. Otherwise clear if PENDING W1C bit i written. Otherwise hold.
  - A set and a clear in the same cycle leave the bit set, so no event is lost.
- Mode switch:
  - Level to edge: pending keeps its current value.
  - Edge to level: pending follows irq_in from the next edge.
  - The mode used in a cycle is the EDGE value before that cycle's write.
- Output: irq <= |(pending & mask) each cycle.
  - Latency: irq_in rises and is sampled at edge N; pending is set at edge N; irq=1 after edge N+1.
  - A masked pending bit stays latched and raises irq one cycle after MASK enables it.
- Read path:
  - readdata <= mux(address) every cycle, independent of chipselect, giving 1-cycle latency.
  - readdata reflects register state before the current edge. A write at edge N is visible in readdata after edge N+1.
- Simultaneous events: a rise and a W1C on the same bit in the same cycle leave it pending. Writes to different registers in consecutive cycles are independent.
- Reset mid-operation: all state returns to reset values at the next edge, including any latched edge events, and irq drops at that edge.

Test Plan:
1. Reset: hold reset_n=0 for 2 clocks with irq_in=8'hFF, then release with irq_in=8'hFF -> irq=0, readdata=0 during reset. After release with EDGE=0: PENDING reads 8'hFF and irq stays 0 (mask=0).
2. Level mode: MASK=16'h0001; pulse irq_in[0] high for cycles 10..14 -> irq high from the edge after 11 through the edge after 15, then 0. VECTOR reads 16'h8000 while active.
3. Edge mode: EDGE=16'h0001, MASK=1; one-cycle pulse on irq_in[0] -> irq latched high until PENDING write 16'h0001, falling 2 edges after the write. A second pulse coincident with the W1C leaves irq high.
4. Priority: EDGE=16'h00FF, MASK=16'h00FF; SWTRIG write 16'h00A4 -> ACTIVE=16'h00A4, VECTOR=16'h8002. After W1C 16'h0004, VECTOR=16'h8005.
5. Masking: edge-capture irq_in[3] with MASK=0 -> irq stays 0 and PENDING=16'h0008. Writing MASK=16'h0008 gives irq=1 one cycle later.
6. Mid-operation reset: with irq=1 and pending=16'h00A4, assert reset_n=0 for 1 cycle -> irq=0, PENDING=0, MASK=0 after that edge, with no residual edge captures.
